// File: rtl/shake_pkg.sv
// Shared constants and FSM encoding for the SHAKE256 absorb front end.
// Imported by the message interface, the pad helper and the top level.
package shake_pkg;

  localparam int RATE            = 1088;
  localparam int STATE_WIDTH     = 1600;
  localparam int LANE_WIDTH      = 64;
  localparam int LANES_PER_BLOCK = 17;
  localparam int RATE_BYTES      = 136;

  localparam logic [7:0] SHAKE_DS = 8'h1F;
  localparam logic [7:0] PAD_END  = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    PAD,
    PERM_REQ,
    PERM_WAIT,
    DONE
  } fsm_t;

endpackage

// File: rtl/shake_absorb_if.sv
// Byte-granular message stream into the absorb block.
// The producer drives valid/data/last/bytes, the absorber drives ready.
interface shake_absorb_if;
  import shake_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [LANE_WIDTH-1:0] in_data;
  logic                  in_last;
  logic [3:0]            in_bytes;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    output in_bytes,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    input  in_bytes,
    output in_ready
  );

endinterface

// File: rtl/shake_pad.sv
// SHAKE multi-rate padding of one rate block.
// Domain byte lands at pad_pos, end marker on the last rate byte.
module shake_pad
  import shake_pkg::*;
(
  input  logic [RATE-1:0] blk,
  input  logic [7:0]      pad_pos,
  output logic [RATE-1:0] padded
);

  // Both XORs stack, giving 8'h9F when pad_pos is the last byte.
  always_comb begin
    padded = blk;
    padded[{pad_pos, 3'b000} +: 8] ^= SHAKE_DS;
    padded[8*RATE_BYTES-1 -: 8]    ^= PAD_END;
  end

endmodule

// File: rtl/shake_absorb.sv
// SHAKE256 absorb: lane collection, padding, state XOR and
// start/done handoff to an external Keccak-f[1600] permutation.
module shake_absorb
  import shake_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   absorb_start,
  shake_absorb_if.slave          msg,
  output logic                   perm_start,
  output logic [STATE_WIDTH-1:0] perm_state_in,
  input  logic                   perm_done,
  input  logic [STATE_WIDTH-1:0] perm_state_out,
  output logic [STATE_WIDTH-1:0] state_out,
  output logic                   absorb_done
);

  fsm_t                   fsm;
  fsm_t                   fsm_nx;
  logic [STATE_WIDTH-1:0] sponge;
  logic [RATE-1:0]        blk;
  logic [RATE-1:0]        blk_wr;
  logic [RATE-1:0]        padded;
  logic [LANE_WIDTH-1:0]  word;
  logic [4:0]             lane_idx;
  logic [7:0]             pad_pos;
  logic [7:0]             pad_pos_nx;
  logic                   extra_pad;
  logic                   final_blk;
  logic                   accept;
  logic                   lane_full;
  logic                   full_go;
  logic                   pad_go;

  localparam int HI_W = STATE_WIDTH - RATE;

  assign msg.in_ready = (fsm == COLLECT);
  assign state_out    = sponge;

  assign accept     = msg.in_valid & msg.in_ready;
  assign lane_full  = (lane_idx == 5'(LANES_PER_BLOCK - 1));
  assign pad_pos_nx = {lane_idx, 3'b000} + {4'b0000, msg.in_bytes};

  // A last word that exactly fills lane 16 closes a full block;
  // the padding then needs a block of its own.
  assign full_go = accept & lane_full &
                   (~msg.in_last | (msg.in_bytes == 4'd8));
  assign pad_go  = accept & msg.in_last & ~full_go;

  // Zero the bytes beyond in_bytes on the final word.
  always_comb begin
    word = msg.in_data;
    if (msg.in_last) begin
      for (int k = 0; k < 8; k++) begin
        if (k >= int'(msg.in_bytes))
          word[8*k +: 8] = 8'h00;
      end
    end
  end

  // Buffer image with the incoming word placed in its lane.
  always_comb begin
    blk_wr = blk;
    blk_wr[{lane_idx, 6'b000000} +: LANE_WIDTH] = word;
  end

  shake_pad u_pad (
    .blk     (blk),
    .pad_pos (pad_pos),
    .padded  (padded)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nx;
  end

  // Next-state logic and handshake strobes.
  always_comb begin
    fsm_nx      = fsm;
    perm_start  = 1'b0;
    absorb_done = 1'b0;
    unique case (fsm)
      IDLE: begin
        if (absorb_start) fsm_nx = COLLECT;
      end
      COLLECT: begin
        if (full_go)     fsm_nx = PERM_REQ;
        else if (pad_go) fsm_nx = PAD;
      end
      PAD: begin
        fsm_nx = PERM_REQ;
      end
      PERM_REQ: begin
        perm_start = 1'b1;
        fsm_nx     = PERM_WAIT;
      end
      PERM_WAIT: begin
        if (perm_done) begin
          if (final_blk)      fsm_nx = DONE;
          else if (extra_pad) fsm_nx = PAD;
          else                fsm_nx = COLLECT;
        end
      end
      DONE: begin
        absorb_done = 1'b1;
        fsm_nx      = IDLE;
      end
      default: fsm_nx = IDLE;
    endcase
  end

  // Datapath: buffer, sponge state, latched permutation input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sponge        <= '0;
      blk           <= '0;
      perm_state_in <= '0;
      lane_idx      <= '0;
      pad_pos       <= '0;
      extra_pad     <= 1'b0;
      final_blk     <= 1'b0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (absorb_start) begin
            sponge    <= '0;
            blk       <= '0;
            lane_idx  <= '0;
            pad_pos   <= '0;
            extra_pad <= 1'b0;
            final_blk <= 1'b0;
          end
        end
        COLLECT: begin
          if (full_go) begin
            perm_state_in <= sponge ^ {{HI_W{1'b0}}, blk_wr};
            blk           <= '0;
            lane_idx      <= '0;
            extra_pad     <= msg.in_last;
          end else if (accept) begin
            blk      <= blk_wr;
            lane_idx <= lane_idx + 5'd1;
            if (msg.in_last) pad_pos <= pad_pos_nx;
          end
        end
        PAD: begin
          perm_state_in <= sponge ^ {{HI_W{1'b0}}, padded};
          blk           <= '0;
          final_blk     <= 1'b1;
        end
        PERM_WAIT: begin
          if (perm_done) begin
            sponge <= perm_state_out;
            if (!final_blk && extra_pad) begin
              pad_pos   <= '0;
              extra_pad <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shake_absorb.sv
// Bench for shake_absorb: identity permutation stub, byte-level
// sponge model and a scoreboard of expected final states.
module tb_shake_absorb;
  import shake_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   absorb_start = 1'b0;
  logic                   perm_start;
  logic [STATE_WIDTH-1:0] perm_state_in;
  logic                   perm_done = 1'b0;
  logic [STATE_WIDTH-1:0] perm_state_out;
  logic [STATE_WIDTH-1:0] state_out;
  logic                   absorb_done;
  logic [2:0]             pcnt = 3'd0;

  int n_chk    = 0;
  int n_fail   = 0;
  int perm_cnt = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  bit prev_pd  = 1'b0;

  logic [STATE_WIDTH-1:0] sb[$];
  logic [7:0]             msg[$];

  shake_absorb_if bus ();

  shake_absorb dut (
    .clk            (clk),
    .reset          (reset),
    .absorb_start   (absorb_start),
    .msg            (bus),
    .perm_start     (perm_start),
    .perm_state_in  (perm_state_in),
    .perm_done      (perm_done),
    .perm_state_out (perm_state_out),
    .state_out      (state_out),
    .absorb_done    (absorb_done)
  );

  always #5 clk = ~clk;

  assign perm_state_out = perm_state_in;

  // Identity permutation: done three cycles after the start cycle.
  always @(posedge clk) begin
    perm_done <= 1'b0;
    if (perm_start) pcnt <= 3'd2;
    else if (pcnt != 3'd0) begin
      pcnt <= pcnt - 3'd1;
      if (pcnt == 3'd1) perm_done <= 1'b1;
    end
  end

  task automatic chk(input string tag,
                     input logic [STATE_WIDTH-1:0] got,
                     input logic [STATE_WIDTH-1:0] exp);
    int li;
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      li = 0;
      for (int i = 24; i >= 0; i--)
        if (got[64*i +: 64] !== exp[64*i +: 64]) li = i;
      $display("FAIL %s lane%0d got=%h exp=%h", tag, li,
               got[64*li +: 64], exp[64*li +: 64]);
    end
  endtask

  // Accepted-word counter.
  always @(posedge clk) begin
    if (!reset && bus.in_valid && bus.in_ready) acc_cnt++;
  end

  // Output monitor: counts strobes and pops the scoreboard.
  always @(negedge clk) begin
    if (perm_start) perm_cnt++;
    if (absorb_done) begin
      done_cnt++;
      chk("done_lat", STATE_WIDTH'(prev_pd), 1);
      chk("sb_avail", STATE_WIDTH'(sb.size() != 0), 1);
      if (sb.size() != 0) chk("final_state", state_out, sb.pop_front());
    end
    prev_pd = perm_done;
  end

  function automatic logic [STATE_WIDTH-1:0] model_state(input int len);
    logic [7:0]             p[];
    logic [STATE_WIDTH-1:0] s;
    int                     nb;
    nb = len / RATE_BYTES + 1;
    p  = new[nb * RATE_BYTES];
    for (int i = 0; i < nb * RATE_BYTES; i++) p[i] = 8'h00;
    for (int i = 0; i < len; i++) p[i] = msg[i];
    p[len]                 ^= 8'h1F;
    p[nb * RATE_BYTES - 1] ^= 8'h80;
    s = '0;
    for (int b = 0; b < nb; b++)
      for (int j = 0; j < RATE_BYTES; j++)
        s[8*j +: 8] ^= p[b*RATE_BYTES + j];
    return s;
  endfunction

  task automatic pulse_start();
    absorb_start = 1'b1;
    @(negedge clk);
    absorb_start = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] d,
                           input logic [3:0] nb,
                           input bit last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_bytes = nb;
    bus.in_last  = last;
    for (int k = 0; k < 64 && !bus.in_ready; k++) @(negedge clk);
    chk("rdy_wait", STATE_WIDTH'(bus.in_ready), 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_rand(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
  endtask

  task automatic run_msg(input bit clean);
    int          len, np, nw, nb, b0, b1, b2;
    bit          last;
    logic [63:0] d;
    len = msg.size();
    np  = len / RATE_BYTES + 1;
    nw  = (len == 0) ? 1 : (len + 7) / 8;
    sb.push_back(model_state(len));
    b0 = perm_cnt;
    b1 = acc_cnt;
    b2 = done_cnt;
    pulse_start();
    for (int w = 0; w < nw; w++) begin
      nb   = (len - 8*w > 8) ? 8 : len - 8*w;
      last = (w == nw - 1);
      d    = clean ? 64'h0 : {$urandom, $urandom};
      for (int k = 0; k < nb; k++) d[8*k +: 8] = msg[8*w + k];
      send_word(d, 4'(nb), last);
      if (!last && (w % LANES_PER_BLOCK) == LANES_PER_BLOCK - 1)
        chk("rdy_drop", STATE_WIDTH'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    for (int k = 0; k < 200 && done_cnt == b2; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("perm_cnt", STATE_WIDTH'(perm_cnt - b0), STATE_WIDTH'(np));
    chk("words", STATE_WIDTH'(acc_cnt - b1), STATE_WIDTH'(nw));
    chk("done_once", STATE_WIDTH'(done_cnt - b2), 1);
  endtask

  task automatic run_abc();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
    run_msg(1'b1);
    chk("abc_lane0", STATE_WIDTH'(state_out[63:0]),
        STATE_WIDTH'(64'h000000001F636261));
    chk("abc_lane16", STATE_WIDTH'(state_out[1087:1024]),
        STATE_WIDTH'(64'h8000000000000000));
    chk("abc_upper", STATE_WIDTH'(state_out[1599:1088]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [STATE_WIDTH-1:0] e;
    int                     d0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.in_bytes = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", STATE_WIDTH'(bus.in_ready), 0);
    chk("rst_pstart", STATE_WIDTH'(perm_start), 0);
    chk("rst_psi", perm_state_in, 0);
    chk("rst_state", state_out, 0);
    chk("rst_done", STATE_WIDTH'(absorb_done), 0);
    reset = 1'b0;
    @(negedge clk);

    msg.delete();
    run_msg(1'b0);
    e = '0;
    e[7:0]       = 8'h1F;
    e[1087:1080] = 8'h80;
    chk("empty_state", state_out, e);

    run_abc();

    fill_rand(135);
    run_msg(1'b0);
    chk("b135", STATE_WIDTH'(state_out[1087:1080]), STATE_WIDTH'(8'h9F));

    fill_rand(136);
    run_msg(1'b0);

    fill_rand(160);
    run_msg(1'b0);

    fill_rand(7);
    run_msg(1'b0);
    fill_rand(300);
    run_msg(1'b0);
    fill_rand(272);
    run_msg(1'b0);

    msg.delete();
    pulse_start();
    send_word(64'h0000000000636261, 4'd3, 1'b1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    for (int k = 0; k < 20 && !perm_start; k++) @(negedge clk);
    chk("mid_pstart", STATE_WIDTH'(perm_start), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_ready", STATE_WIDTH'(bus.in_ready), 0);
    chk("mid_pstart0", STATE_WIDTH'(perm_start), 0);
    chk("mid_psi", perm_state_in, 0);
    chk("mid_state", state_out, 0);
    chk("mid_done", STATE_WIDTH'(absorb_done), 0);
    reset = 1'b0;
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    chk("late_done", STATE_WIDTH'(done_cnt - d0), 0);
    chk("late_state", state_out, 0);

    run_abc();

    chk("sb_drained", STATE_WIDTH'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
